// File: rtl/game_state_controller.sv
// game_state_controller: round sequencer for the maze game.
// Tracks lives and remaining pellets, sequences the round phases and drives
// the sprite spawn-reset pulse and the motion freeze level.
// All outputs are registered; state transitions land on the edge after the
// inputs are sampled. The current phase is visible on the state output.
module game_state_controller #(
  parameter int          LIVES        = 3,
  parameter int          READY_CYCLES = 50000000,
  parameter int          DEATH_CYCLES = 25000000,
  parameter logic [11:0] TOTAL_FOOD   = 12'd1000,
  parameter int          TIMER_W      = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        pacman_is_dead,
  input  logic        food_eaten,
  output logic        game_rst,
  output logic        freeze,
  output logic [1:0]  lives,
  output logic [11:0] pellets_left,
  output logic        game_over,
  output logic        level_clear,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READY       = 3'd1,
    S_PLAY        = 3'd2,
    S_DYING       = 3'd3,
    S_GAME_OVER   = 3'd4,
    S_LEVEL_CLEAR = 3'd5
  } state_t;

  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES);
  localparam logic [TIMER_W-1:0] READY_LOAD = TIMER_W'(READY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DEATH_LOAD = TIMER_W'(DEATH_CYCLES - 1);

  state_t             state_q;
  logic [TIMER_W-1:0] timer;
  logic               start_q;
  logic               start_press;

  // A held button yields a single press: rising edge against last sample.
  assign start_press = start_btn & ~start_q;
  assign state       = state_q;

  // Phase sequencer; every output is set alongside the transition that
  // changes it so the outputs line up with the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lives        <= LIVES_LOAD;
      pellets_left <= TOTAL_FOOD;
      timer        <= '0;
      start_q      <= 1'b0;
      freeze       <= 1'b1;
      game_rst     <= 1'b0;
      game_over    <= 1'b0;
      level_clear  <= 1'b0;
    end else begin
      start_q  <= start_btn;
      game_rst <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_press) begin
            state_q      <= S_READY;
            lives        <= LIVES_LOAD;
            pellets_left <= TOTAL_FOOD;
            timer        <= READY_LOAD;
            game_rst     <= 1'b1;
            freeze       <= 1'b1;
          end
        end
        S_READY: begin
          // Collisions, pellets and the start button are all ignored here.
          if (timer == '0) begin
            state_q <= S_PLAY;
            freeze  <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_PLAY: begin
          if (pacman_is_dead) begin
            // Death wins over a pellet eaten in the same cycle.
            state_q <= S_DYING;
            lives   <= lives - 2'd1;
            timer   <= DEATH_LOAD;
            freeze  <= 1'b1;
          end else if (food_eaten && pellets_left == 12'd1) begin
            pellets_left <= 12'd0;
            state_q      <= S_LEVEL_CLEAR;
            level_clear  <= 1'b1;
            freeze       <= 1'b1;
          end else if (food_eaten && pellets_left != 12'd0) begin
            pellets_left <= pellets_left - 12'd1;
          end
        end
        S_DYING: begin
          // A collision level still held here costs no further lives.
          if (timer == '0) begin
            if (lives == 2'd0) begin
              state_q   <= S_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state_q  <= S_READY;
              timer    <= READY_LOAD;
              game_rst <= 1'b1;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_GAME_OVER: begin
          if (start_press) begin
            state_q      <= S_READY;
            lives        <= LIVES_LOAD;
            pellets_left <= TOTAL_FOOD;
            timer        <= READY_LOAD;
            game_rst     <= 1'b1;
            game_over    <= 1'b0;
          end
        end
        S_LEVEL_CLEAR: begin
          // New level: pellets refill, lives carry over.
          if (start_press) begin
            state_q      <= S_READY;
            pellets_left <= TOTAL_FOOD;
            timer        <= READY_LOAD;
            game_rst     <= 1'b1;
            level_clear  <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          freeze      <= 1'b1;
          game_over   <= 1'b0;
          level_clear <= 1'b0;
        end
      endcase
    end
  end

endmodule
